rf_write_arbiter: RTL and testbench
===================================

RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 3: max consecutive cycles a pending LU request may lose arbitration (legal 1..15).
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 wb_valid  input  1  pipeline WB-stage write request.
REQ-005 wb_rd  input  5  WB destination register.
REQ-006 wb_data  input  32  WB write data.
REQ-007 wb_ready  output  1  WB request accepted this cycle; pipeline holds WB when low.
REQ-008 lu_valid  input  1  long-latency unit (load/div) write request.
REQ-009 lu_rd  input  5  LU destination register.
REQ-010 lu_data  input  32  LU write data.
REQ-011 lu_ready  output  1  LU request accepted this cycle.
REQ-012 issue_valid  input  1  ID stage dispatching a long-latency op.
REQ-013 issue_rd  input  5  destination of dispatched op.
REQ-014 issue_ready  output  1  dispatch permitted (no WAW on issue_rd).
REQ-015 rs1_addr, rs2_addr  input  5 each  ID source registers for scoreboard lookup.
REQ-016 rs1_busy, rs2_busy  output  1 each  source has an outstanding long-latency write.
REQ-017 rf_we  output  1  register-file write enable.
REQ-018 rf_waddr  output  5  register-file write address.
REQ-019 rf_wdata  output  32  register-file write data.

Function
REQ-020 One grant per cycle; grant = WB if wb_valid and not forcing, else LU if lu_valid.
REQ-021 FSM states NORMAL and FORCE_LU; NORMAL->FORCE_LU when starve counter reaches STARVE_LIMIT with lu_valid high; FORCE_LU->NORMAL after exactly one cycle.
REQ-022 In FORCE_LU: lu_ready=1 (lu_valid guaranteed), wb_ready=0.
REQ-023 Starve counter: +1 each cycle lu_valid=1 and lu_ready=0; cleared to 0 on LU grant or lu_valid=0; saturates at 15.
REQ-024 wb_ready and lu_ready combinational from current inputs and state; no ready without matching valid.
REQ-025 Granted request registered into rf_we/rf_waddr/rf_wdata on the grant edge; RF write visible one cycle after grant (latency 1).
REQ-026 No grant in a cycle -> rf_we=0 next cycle; rf_waddr/rf_wdata hold last value.
REQ-027 Granted rd=0: request consumed (ready=1), rf_we=0, scoreboard unchanged.
REQ-028 Scoreboard: 32 busy bits, bit 0 hardwired 0.
REQ-029 issue_ready = !busy[issue_rd]; issue_valid && issue_ready && issue_rd!=0 sets busy[issue_rd] on next edge.
REQ-030 LU grant clears busy[lu_rd] on the grant edge, concurrent with rf_we assertion; downstream bypass covers the following cycle.
REQ-031 Same-cycle issue and LU-clear of the same rd: issue_ready=0 (bit still set), clear wins, bit ends 0.
REQ-032 rs1_busy/rs2_busy = busy[rs1_addr]/busy[rs2_addr], combinational.
REQ-033 WB grants never modify the scoreboard.

Reset
REQ-034 rst_n low: state=NORMAL, starve counter=0, all busy bits=0, rf_we=0, rf_waddr=0, rf_wdata=0, immediately and asynchronously.
REQ-035 Requests in flight at reset are dropped; no write issued after release until a new grant.

Verification
REQ-036 wb_valid=1 rd=5 data=0xA5A5A5A5, lu_valid=0 -> wb_ready=1; next cycle rf_we=1 rf_waddr=5 rf_wdata=0xA5A5A5A5.
REQ-037 wb_valid and lu_valid held high continuously, STARVE_LIMIT=3 -> WB granted cycles 0-2, LU granted cycle 3 with wb_ready=0, WB resumes cycle 4.
REQ-038 issue rd=7 -> rs1_addr=7 gives rs1_busy=1 next cycle; second issue rd=7 sees issue_ready=0; LU write rd=7 clears busy on grant edge.
REQ-039 issue rd=9 and LU grant rd=9 same cycle with busy[9]=1 -> issue_ready=0, busy[9]=0 after edge.
REQ-040 wb_valid rd=0 -> wb_ready=1, rf_we=0 next cycle; issue rd=0 -> issue_ready=1, no busy bit set.
REQ-041 rst_n asserted mid-starvation with busy[3]=1 -> counter=0, busy[3]=0, rf_we=0 without clock edge.

Source files
------------

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: arbitrates WB and long-latency writes into the single
// register-file write port and keeps the long-latency busy scoreboard.
//
// Ports
//   clk, rst_n                   clock, async active-low reset
//   wb_valid/wb_rd/wb_data       WB-stage write request, wb_ready accepts
//   lu_valid/lu_rd/lu_data       long-latency unit write, lu_ready accepts
//   issue_valid/issue_rd         long-latency dispatch, issue_ready = no WAW
//   rs1_addr/rs2_addr            ID source lookups -> rs1_busy/rs2_busy
//   rf_we/rf_waddr/rf_wdata      registered register-file write port
module rf_write_arbiter #(
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        wb_ready,
    input  logic        lu_valid,
    input  logic [4:0]  lu_rd,
    input  logic [31:0] lu_data,
    output logic        lu_ready,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    output logic        issue_ready,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    output logic        rs1_busy,
    output logic        rs2_busy,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic {
        NORMAL,
        FORCE_LU
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [3:0]  starve_q;
    logic [3:0]  starve_d;
    logic [31:0] busy_q;
    logic [31:0] busy_d;

    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;

    // WB wins unless LU has been starved long enough to force a slot.
    always_comb begin
        wb_ready = wb_valid && (state_q == NORMAL);
        lu_ready = lu_valid && ((state_q == FORCE_LU) || !wb_valid);
    end

    always_comb begin
        starve_d = 4'd0;
        state_d  = NORMAL;
        if (lu_valid && !lu_ready) begin
            starve_d = (starve_q == 4'd15) ? 4'd15 : starve_q + 4'd1;
        end
        unique case (state_q)
            NORMAL: begin
                // Enter FORCE_LU on the edge where the count hits the limit
                // so the forced grant lands in the very next cycle.
                if (lu_valid && !lu_ready && (starve_d >= LIMIT)) begin
                    state_d = FORCE_LU;
                end
            end
            FORCE_LU: begin
                state_d = NORMAL;
            end
            default: begin
                state_d = NORMAL;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= NORMAL;
            starve_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    // Writes to x0 are consumed but never reach the register file.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = rf_waddr;
        wr_data = rf_wdata;
        unique case (1'b1)
            wb_ready: begin
                wr_en   = (wb_rd != 5'd0);
                wr_addr = wb_rd;
                wr_data = wb_data;
            end
            lu_ready: begin
                wr_en   = (lu_rd != 5'd0);
                wr_addr = lu_rd;
                wr_data = lu_data;
            end
            default: begin
                wr_en = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we    <= 1'b0;
            rf_waddr <= 5'd0;
            rf_wdata <= 32'd0;
        end else begin
            rf_we <= wr_en;
            if (wr_en) begin
                rf_waddr <= wr_addr;
                rf_wdata <= wr_data;
            end
        end
    end

    assign issue_ready = !busy_q[issue_rd];
    assign rs1_busy    = busy_q[rs1_addr];
    assign rs2_busy    = busy_q[rs2_addr];

    // Clear is applied after set so a same-cycle LU retire of the same rd
    // leaves the bit clear.
    always_comb begin
        busy_d = busy_q;
        if (issue_valid && issue_ready && (issue_rd != 5'd0)) begin
            busy_d[issue_rd] = 1'b1;
        end
        if (lu_ready && (lu_rd != 5'd0)) begin
            busy_d[lu_rd] = 1'b0;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 32'd0;
        end else begin
            busy_q <= busy_d;
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: directed and random stimulus, scoreboard queues
// filled by a behavioural model and drained by independent monitors.
module tb_rf_write_arbiter;

    localparam int LIM = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_data = '0;
    logic        wb_ready;
    logic        lu_valid = 1'b0;
    logic [4:0]  lu_rd = '0;
    logic [31:0] lu_data = '0;
    logic        lu_ready;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_rd = '0;
    logic        issue_ready;
    logic [4:0]  rs1_addr = '0;
    logic [4:0]  rs2_addr = '0;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    always #5 clk = ~clk;

    rf_write_arbiter #(.STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .wb_ready(wb_ready),
        .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_data(lu_data),
        .lu_ready(lu_ready),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .issue_ready(issue_ready),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
    );

    typedef struct packed {
        logic wr;
        logic lr;
        logic ir;
        logic b1;
        logic b2;
    } comb_t;

    typedef struct packed {
        logic        we;
        logic [4:0]  a;
        logic [31:0] d;
    } rf_t;

    comb_t cq[$];
    rf_t   rq[$];
    int    errors = 0;
    int    checks = 0;

    // Reference model: busy set, count of consecutive LU losses, last write.
    logic [31:0] m_busy = '0;
    int          m_loss = 0;
    logic [4:0]  m_addr = '0;
    logic [31:0] m_data = '0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
                     $time);
        end
    endtask

    initial begin : comb_mon
        comb_t e;
        forever begin
            @(negedge clk);
            #2;
            if (cq.size() > 0) begin
                e = cq.pop_front();
                chk("wb_ready", wb_ready, e.wr);
                chk("lu_ready", lu_ready, e.lr);
                chk("issue_ready", issue_ready, e.ir);
                chk("rs1_busy", rs1_busy, e.b1);
                chk("rs2_busy", rs2_busy, e.b2);
            end
        end
    end

    initial begin : rf_mon
        rf_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && rq.size() > 0) begin
                e = rq.pop_front();
                chk("rf_we", rf_we, e.we);
                chk("rf_waddr", rf_waddr, e.a);
                chk("rf_wdata", rf_wdata, e.d);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1, "timeout");
    end

    task automatic step(
        input logic wv, input logic [4:0] wrd, input logic [31:0] wd,
        input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
        input logic iv, input logic [4:0] ird,
        input logic [4:0] r1, input logic [4:0] r2,
        output logic wg, output logic lg);
        comb_t c;
        rf_t   r;
        logic  force_lu;
        @(negedge clk);
        wb_valid = wv; wb_rd = wrd; wb_data = wd;
        lu_valid = lv; lu_rd = lrd; lu_data = ld;
        issue_valid = iv; issue_rd = ird;
        rs1_addr = r1; rs2_addr = r2;
        #1;
        // LU that has already lost LIM cycles in a row must win now.
        force_lu = lv && (m_loss >= LIM);
        wg = wv && !force_lu;
        lg = lv && !wg;
        c.wr = wg; c.lr = lg;
        c.ir = !m_busy[ird];
        c.b1 = m_busy[r1];
        c.b2 = m_busy[r2];
        cq.push_back(c);
        m_loss = (lv && !lg) ? ((m_loss < 15) ? m_loss + 1 : 15) : 0;
        r.we = 1'b0;
        if (wg && wrd != 0) begin
            r.we = 1'b1; m_addr = wrd; m_data = wd;
        end else if (lg && lrd != 0) begin
            r.we = 1'b1; m_addr = lrd; m_data = ld;
        end
        r.a = m_addr;
        r.d = m_data;
        rq.push_back(r);
        if (iv && !m_busy[ird] && ird != 0) m_busy[ird] = 1'b1;
        if (lg && lrd != 0) m_busy[lrd] = 1'b0;
    endtask

    task automatic model_reset();
        cq.delete();
        rq.delete();
        m_busy = '0;
        m_loss = 0;
        m_addr = '0;
        m_data = '0;
    endtask

    task automatic idle_inputs();
        wb_valid = 0; lu_valid = 0; issue_valid = 0;
        wb_rd = 0; lu_rd = 0; issue_rd = 0;
        wb_data = 0; lu_data = 0;
        rs1_addr = 0; rs2_addr = 0;
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic starve_seq(input string nm);
        logic wg, lg;
        logic [4:0] pat;
        pat = 5'b10111;
        for (int i = 0; i < 5; i++) begin
            step(1, 5'(10 + i), 32'h100 + i, 1, 5'd2, 32'hBEEF,
                 0, 0, 0, 0, wg, lg);
            chk({nm, "_wb_ready"}, wb_ready, pat[i]);
            chk({nm, "_lu_ready"}, lu_ready, !pat[i]);
        end
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, wg, lg);
    endtask

    logic        wg, lg;
    logic        pw, pl;
    logic [4:0]  pwrd, plrd;
    logic [31:0] pwd, pld;

    initial begin
        idle_inputs();
        #3;
        chk("reset_rf_we", rf_we, 0);
        chk("reset_rf_waddr", rf_waddr, 0);
        chk("reset_rf_wdata", rf_wdata, 0);
        release_reset();

        step(0, 0, 0, 0, 0, 0, 0, 0, 5'd1, 5'd31, wg, lg);

        step(1, 5'd5, 32'hA5A5A5A5, 0, 0, 0, 0, 0, 0, 0, wg, lg);
        chk("wb5_ready", wb_ready, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, wg, lg);
        chk("wb5_rf_we", rf_we, 1);
        chk("wb5_rf_wdata", rf_wdata, 32'hA5A5A5A5);

        starve_seq("starve");

        step(0, 0, 0, 0, 0, 0, 1, 5'd7, 5'd7, 0, wg, lg);
        chk("issue7_ready", issue_ready, 1);
        step(0, 0, 0, 0, 0, 0, 1, 5'd7, 5'd7, 0, wg, lg);
        chk("rs1_busy7", rs1_busy, 1);
        chk("issue7_waw", issue_ready, 0);
        step(0, 0, 0, 1, 5'd7, 32'h77, 0, 0, 5'd7, 0, wg, lg);
        chk("lu7_ready", lu_ready, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 5'd7, 0, wg, lg);
        chk("rs1_busy7_clr", rs1_busy, 0);

        step(0, 0, 0, 0, 0, 0, 1, 5'd9, 0, 0, wg, lg);
        step(0, 0, 0, 1, 5'd9, 32'h99, 1, 5'd9, 0, 5'd9, wg, lg);
        chk("issue9_ready", issue_ready, 0);
        chk("rs2_busy9", rs2_busy, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 5'd9, 0, wg, lg);
        chk("busy9_after", rs1_busy, 0);

        step(1, 5'd0, 32'hDEAD, 0, 0, 0, 1, 5'd0, 0, 0, wg, lg);
        chk("wb0_ready", wb_ready, 1);
        chk("issue0_ready", issue_ready, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 5'd0, 0, wg, lg);
        chk("wb0_rf_we", rf_we, 0);
        chk("busy0", rs1_busy, 0);

        step(0, 0, 0, 0, 0, 0, 1, 5'd3, 5'd3, 0, wg, lg);
        step(1, 5'd4, 32'h44, 1, 5'd2, 32'h22, 0, 0, 5'd3, 0, wg, lg);
        step(1, 5'd4, 32'h44, 1, 5'd2, 32'h22, 0, 0, 5'd3, 0, wg, lg);
        #2;
        chk("pre_rst_busy3", rs1_busy, 1);
        chk("pre_rst_rf_we", rf_we, 1);
        rst_n = 1'b0;
        #1;
        chk("async_rf_we", rf_we, 0);
        chk("async_rf_waddr", rf_waddr, 0);
        chk("async_rf_wdata", rf_wdata, 0);
        chk("async_busy3", rs1_busy, 0);
        model_reset();
        idle_inputs();
        release_reset();
        step(0, 0, 0, 0, 0, 0, 0, 0, 5'd3, 0, wg, lg);
        starve_seq("post_rst");

        pw = 0; pl = 0;
        pwrd = 0; plrd = 0; pwd = 0; pld = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!pw && $urandom_range(0, 99) < 65) begin
                pw = 1;
                pwrd = 5'($urandom_range(0, 7));
                pwd = $urandom;
            end
            if (!pl && $urandom_range(0, 99) < 45) begin
                pl = 1;
                plrd = 5'($urandom_range(0, 7));
                pld = $urandom;
            end
            step(pw, pwrd, pwd, pl, plrd, pld,
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 31)), 5'($urandom_range(0, 7)),
                 wg, lg);
            if (wg) pw = 0;
            if (lg) pl = 0;
        end
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, wg, lg);
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
